imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Shares the single byte-addressable instruction-memory port between the core's fetch
//  unit (word reads) and a program loader/debug port (word reads, byte-strobed writes).
//  Sequences each write as four byte-write cycles to match the byte-wide memory write path.
//  Sits between the fetch stage/loader and the instruction memory array.
// PARAMETERS
//  ADDR_W       32    address width of all ports
//  DEPTH_BYTES  4096  memory size in bytes; any word reaching beyond it is out of range
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       reset; asynchronous, active-high
//  f_req_valid  in   1       fetch request valid; held with f_addr until accepted
//  f_req_ready  out  1       fetch request accepted this cycle
//  f_addr       in   ADDR_W  fetch byte address
//  f_rsp_valid  out  1       one-cycle pulse: fetch data valid
//  f_rsp_instr  out  32      fetched word, little-endian
//  f_rsp_err    out  1       fetch was misaligned or out of range
//  l_req_valid  in   1       loader request valid; held with l_* until accepted
//  l_req_ready  out  1       loader request accepted this cycle
//  l_we         in   1       1 = write, 0 = read
//  l_addr       in   ADDR_W  loader byte address
//  l_wdata      in   32      write word; byte i = l_wdata[8i+7:8i]
//  l_be         in   4       byte enables
//  l_rsp_valid  out  1       one-cycle pulse: loader op complete
//  l_rsp_rdata  out  32      read data; 0 for writes
//  l_rsp_err    out  1       loader op was misaligned or out of range
//  mem_addr     out  ADDR_W  memory address
//  mem_rdata    in   32      combinational word read of mem_addr..mem_addr+3
//  mem_we       out  1       byte write strobe
//  mem_wdata    out  8       byte write data
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pending request dropped, no response issued.
//   Reset during WR deasserts mem_we immediately; a partially written word is acceptable.
//  FSM: IDLE -> RD (any read) | WR (loader write) | ERR (bad address); RD/ERR -> IDLE;
//   WR: 4 cycles, byte index 0..3, then IDLE.
//  Accept: only in IDLE; ready is combinational, high only for the granted valid requester.
//   Request fields are latched at acceptance (cycle T).
//  Arbitration: fixed priority; loader wins over fetch when both are valid.
//  Address check at accept: addr[1:0]!=0 or addr > DEPTH_BYTES-4 -> ERR; no memory access.
//   Response at T+2: err=1, data=32'h00000013 for fetch and 0 for loader.
//  RD (T+1): mem_addr=latched addr; mem_rdata registered; rsp_valid pulse at T+2.
//   IDLE is re-entered at T+2 and may accept at T+2: one read every 2 cycles.
//  WR (T+1..T+4): cycle k drives mem_addr=addr+k and mem_wdata=byte k; mem_we=l_be[k].
//   All 4 cycles are spent even when l_be=0. l_rsp_valid pulses at T+5 with rdata 0.
//  Idle memory port: mem_addr=0, mem_we=0, mem_wdata=0.
//  Response pulses last exactly one cycle; there is no response backpressure.
//   rsp data/err hold until the next response.
// CONFIGURATION
//  IMEM_ARB_RR_EN defined: round-robin arbitration.
//   A last-grant bit points at the requester served last; the other requester wins a tie.
//   Reset value: last=loader, so fetch wins the first tie.
//   Only contested grants update the bit.
//  Undefined: fixed loader priority as above; the last-grant bit is absent.
// TESTING
//  1 mem[0x10..0x13]=93,00,50,00; fetch 0x10 -> f_rsp_valid at T+2, instr 0x00500093, err 0.
//  2 loader write 0x20 data 0xDEADBEEF be 4'b1111 -> mem_we T+1..T+4, addr 0x20..0x23,
//    bytes EF,BE,AD,DE; l_rsp_valid at T+5; then fetch 0x20 -> 0xDEADBEEF.
//  3 loader write 0x24 data 0x11223344 be 4'b0101 -> only 0x24=44 and 0x26=22 written;
//    mem_we low at T+2 and T+4.
//  4 f and l valid together in IDLE, 4 back-to-back -> fixed mode: L,L,L,L with fetch stalled;
//    RR mode: F,L,F,L.
//  5 fetch 0x02 -> err=1, instr 0x00000013, no mem_we; with DEPTH 4096 fetch 0xFFC err=0
//    and fetch 0x1000 err=1.
//  6 rst asserted mid-WR at T+2 -> mem_we=0 and busy=0 immediately; no l_rsp_valid;
//    next request accepted in IDLE.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// Instruction-memory port arbiter: fetch word reads and loader reads / byte-sequenced writes.
// Define IMEM_ARB_RR_EN for round-robin arbitration; otherwise the loader has fixed priority.
module imem_access_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_rsp_valid,
    output logic [31:0]       f_rsp_instr,
    output logic              f_rsp_err,
    input  logic              l_req_valid,
    output logic              l_req_ready,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    input  logic [3:0]        l_be,
    output logic              l_rsp_valid,
    output logic [31:0]       l_rsp_rdata,
    output logic              l_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [31:0]       LP_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ERR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_src_l;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [1:0]         r_idx;

    logic               w_idle;
    logic               w_prio_l;
    logic               w_grant_l;
    logic               w_grant_f;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_bad_addr;

`ifdef IMEM_ARB_RR_EN
    // r_last_l = 1 when the loader won the most recent contested grant
    logic r_last_l;

    assign w_prio_l = ~r_last_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_l <= 1'b1;
        end else if (w_accept && f_req_valid && l_req_valid) begin
            r_last_l <= w_grant_l;
        end
    end
`else
    assign w_prio_l = 1'b1;
`endif

    assign w_idle     = (r_state == ST_IDLE);
    assign w_grant_l  = l_req_valid & (~f_req_valid | w_prio_l);
    assign w_grant_f  = f_req_valid & ~w_grant_l;
    assign w_accept   = w_idle & (w_grant_l | w_grant_f);
    assign w_sel_addr = w_grant_l ? l_addr : f_addr;
    assign w_bad_addr = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr > LP_MAX_ADDR);

    assign l_req_ready = w_idle & w_grant_l;
    assign f_req_ready = w_idle & w_grant_f;
    assign busy        = ~w_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad_addr) begin
                        w_state_nxt = ST_ERR;
                    end else if (w_grant_l && l_we) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD:   w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            ST_WR: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_l <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_src_l <= w_grant_l;
            r_addr  <= w_sel_addr;
            r_wdata <= l_wdata;
            r_be    <= l_be;
            r_idx   <= '0;
        end else if (r_state == ST_WR) begin
            r_idx   <= r_idx + 2'd1;
        end
    end

    // Responses are registered so they appear one cycle after the memory/error cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rsp_valid <= 1'b0;
            f_rsp_instr <= '0;
            f_rsp_err   <= 1'b0;
            l_rsp_valid <= 1'b0;
            l_rsp_rdata <= '0;
            l_rsp_err   <= 1'b0;
        end else begin
            f_rsp_valid <= 1'b0;
            l_rsp_valid <= 1'b0;
            case (r_state)
                ST_RD: begin
                    if (r_src_l) begin
                        l_rsp_valid <= 1'b1;
                        l_rsp_rdata <= mem_rdata;
                        l_rsp_err   <= 1'b0;
                    end else begin
                        f_rsp_valid <= 1'b1;
                        f_rsp_instr <= mem_rdata;
                        f_rsp_err   <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (r_src_l) begin
                        l_rsp_valid <= 1'b1;
                        l_rsp_rdata <= '0;
                        l_rsp_err   <= 1'b1;
                    end else begin
                        f_rsp_valid <= 1'b1;
                        f_rsp_instr <= LP_NOP;
                        f_rsp_err   <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (r_idx == 2'd3) begin
                        l_rsp_valid <= 1'b1;
                        l_rsp_rdata <= '0;
                        l_rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            ST_RD: mem_addr = r_addr;
            ST_WR: begin
                mem_addr  = r_addr + ADDR_W'(r_idx);
                mem_we    = r_be[r_idx];
                mem_wdata = r_wdata[8*r_idx +: 8];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a byte-array memory model.
// Expectations follow the default build unless IMEM_ARB_RR_EN is defined.
module tb_imem_access_arbiter;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              f_req_valid = 1'b0;
    logic              f_req_ready;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_rsp_valid;
    logic [31:0]       f_rsp_instr;
    logic              f_rsp_err;
    logic              l_req_valid = 1'b0;
    logic              l_req_ready;
    logic              l_we = 1'b0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [31:0]       l_wdata = '0;
    logic [3:0]        l_be = '0;
    logic              l_rsp_valid;
    logic [31:0]       l_rsp_rdata;
    logic              l_rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              busy;

    logic [7:0] mem [0:DEPTH-1];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         we_count = 0;

    imem_access_arbiter #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_instr(f_rsp_instr), .f_rsp_err(f_rsp_err),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_we(l_we),
        .l_addr(l_addr), .l_wdata(l_wdata), .l_be(l_be),
        .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata), .l_rsp_err(l_rsp_err),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = '0;
        if (mem_addr <= ADDR_W'(DEPTH - 4)) begin
            mem_rdata = {mem[mem_addr[11:0] + 12'd3], mem[mem_addr[11:0] + 12'd2],
                         mem[mem_addr[11:0] + 12'd1], mem[mem_addr[11:0]]};
        end
    end

    always @(posedge clk) begin
        if (mem_we) begin
            we_count <= we_count + 1;
            if (mem_addr < ADDR_W'(DEPTH)) mem[mem_addr[11:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                            input logic exp_err);
        int we0;
        we0 = we_count;
        @(negedge clk);
        f_req_valid = 1'b1;
        f_addr      = addr;
        #1 chk("f_ready", f_req_ready, 1);
        @(negedge clk);
        f_req_valid = 1'b0;
        chk("f_busy_t1", busy, 1);
        chk("f_rsp_early", f_rsp_valid, 0);
        @(negedge clk);
        chk("f_rsp_valid", f_rsp_valid, 1);
        chk("f_rsp_instr", f_rsp_instr, exp_instr);
        chk("f_rsp_err", f_rsp_err, exp_err);
        chk("f_no_write", we_count, we0);
        @(negedge clk);
        chk("f_rsp_pulse", f_rsp_valid, 0);
    endtask

    task automatic do_lread(input logic [31:0] addr, input logic [31:0] exp_data);
        @(negedge clk);
        l_req_valid = 1'b1;
        l_we        = 1'b0;
        l_addr      = addr;
        #1 chk("lr_ready", l_req_ready, 1);
        @(negedge clk);
        l_req_valid = 1'b0;
        @(negedge clk);
        chk("lr_rsp_valid", l_rsp_valid, 1);
        chk("lr_rdata", l_rsp_rdata, exp_data);
        chk("lr_err", l_rsp_err, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic exp_err);
        int we0;
        we0 = we_count;
        @(negedge clk);
        l_req_valid = 1'b1;
        l_we        = 1'b1;
        l_addr      = addr;
        l_wdata     = data;
        l_be        = be;
        #1 chk("w_ready", l_req_ready, 1);
        if (!exp_err) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                l_req_valid = 1'b0;
                chk($sformatf("w_we_%0d", k), mem_we, be[k]);
                chk($sformatf("w_addr_%0d", k), mem_addr, addr + k);
                if (be[k]) chk($sformatf("w_data_%0d", k), mem_wdata, data[8*k +: 8]);
                chk($sformatf("w_rsp_early_%0d", k), l_rsp_valid, 0);
            end
        end else begin
            @(negedge clk);
            l_req_valid = 1'b0;
            chk("w_err_no_we", mem_we, 0);
        end
        @(negedge clk);
        chk("w_rsp_valid", l_rsp_valid, 1);
        chk("w_rsp_rdata", l_rsp_rdata, 0);
        chk("w_rsp_err", l_rsp_err, exp_err);
        if (exp_err) chk("w_err_writes", we_count, we0);
        else         chk("w_writes", we_count, we0 + $countones(be));
        l_we = 1'b0;
    endtask

    initial begin
        int grants [4];
        int exp_g  [4];
        int ng;
        int pulses;

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        mem[16'h10] = 8'h93; mem[16'h11] = 8'h00; mem[16'h12] = 8'h50; mem[16'h13] = 8'h00;
        mem[16'h24] = 8'hAA; mem[16'h25] = 8'hBB; mem[16'h26] = 8'hCC; mem[16'h27] = 8'hDD;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_f_rsp", f_rsp_valid, 0);
        chk("rst_l_rsp", l_rsp_valid, 0);
        chk("rst_f_instr", f_rsp_instr, 0);
        rst = 1'b0;

        do_fetch(32'h10, 32'h0050_0093, 1'b0);
        do_write(32'h20, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        do_fetch(32'h20, 32'hDEAD_BEEF, 1'b0);
        do_write(32'h24, 32'h1122_3344, 4'b0101, 1'b0);
        do_lread(32'h24, 32'hDD22_BB44);
        do_write(32'h40, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        do_lread(32'h40, 32'h0000_0000);

        do_fetch(32'h02, 32'h0000_0013, 1'b1);
        do_fetch(32'hFFC, 32'h0000_0000, 1'b0);
        do_fetch(32'h1000, 32'h0000_0013, 1'b1);
        do_write(32'h22, 32'h1234_5678, 4'b1111, 1'b1);

        // Both requesters held valid; record the order of grants
`ifdef IMEM_ARB_RR_EN
        exp_g = '{2, 1, 2, 1};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        ng = 0;
        @(negedge clk);
        f_req_valid = 1'b1; f_addr = 32'h10;
        l_req_valid = 1'b1; l_we = 1'b0; l_addr = 32'h20;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (l_req_ready && f_req_ready) chk("arb_both_ready", 1, 0);
            if (l_req_ready)      begin grants[ng] = 1; ng++; end
            else if (f_req_ready) begin grants[ng] = 2; ng++; end
            @(negedge clk);
        end
        f_req_valid = 1'b0;
        l_req_valid = 1'b0;
        chk("arb_grant_count", ng, 4);
        for (int i = 0; i < ng; i++) chk($sformatf("arb_grant_%0d", i), grants[i], exp_g[i]);
        repeat (3) @(negedge clk);

        // Reset in the middle of a write
        @(negedge clk);
        l_req_valid = 1'b1; l_we = 1'b1; l_addr = 32'h30; l_wdata = 32'h5566_7788; l_be = 4'hF;
        #1 chk("rw_ready", l_req_ready, 1);
        @(negedge clk);
        l_req_valid = 1'b0;
        chk("rw_we_t1", mem_we, 1);
        @(negedge clk);
        chk("rw_we_t2", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rw_we_rst", mem_we, 0);
        chk("rw_busy_rst", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        l_we = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (l_rsp_valid) pulses++;
        end
        chk("rw_no_rsp", pulses, 0);
        do_fetch(32'h10, 32'h0050_0093, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
